// File: rtl/fp_mul_arb_pkg.sv
// Shared types and constants for the floating-point multiplier arbiter.
package fp_mul_arb_pkg;

    localparam int FP_W = 32;
    localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_picker #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt_onehot,
    output logic [IDW-1:0] gnt_idx
);

    logic           found;
    logic [IDW-1:0] k;

    // Scan the requests in rotated order and keep the first hit.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        found      = 1'b0;
        k          = '0;
        for (int i = 0; i < N; i++) begin
            k = IDW'((int'(ptr) + i) % N);
            if (!found && req[k]) begin
                found         = 1'b1;
                gnt_onehot[k] = 1'b1;
                gnt_idx       = k;
            end
        end
    end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin scheduler sharing one FP multiplier (one operation in flight) between
// N requesters, with a watchdog that turns a silent multiplier into an error response.
module fp_mul_arbiter
    import fp_mul_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 32,
    parameter int IDW     = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req_valid,
    input  logic [N*FP_W-1:0] req_op1,
    input  logic [N*FP_W-1:0] req_op2,
    output logic [N-1:0]      req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [FP_W-1:0]   rsp_data,
    output logic              rsp_err,
    output logic              mul_ready,
    output logic [FP_W-1:0]   mul_op1,
    output logic [FP_W-1:0]   mul_op2,
    input  logic [FP_W-1:0]   mul_res,
    input  logic              mul_done,
    output logic              busy
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    state_t            state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [IDW-1:0]    gid_q, gid_d;
    logic [FP_W-1:0]   op1_q, op1_d;
    logic [FP_W-1:0]   op2_q, op2_d;
    logic [FP_W-1:0]   data_q, data_d;
    logic              err_q, err_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N-1:0]      gnt_onehot;
    logic [IDW-1:0]    gnt_idx;

    rr_picker #(
        .N   (N),
        .IDW (IDW)
    ) u_picker (
        .req        (req_valid),
        .ptr        (ptr_q),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx)
    );

    // Next-state logic; req_ready is the only combinational output (IDLE only).
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gid_d     = gid_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        data_d    = data_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        req_ready = '0;
        unique case (state_q)
            StIdle: begin
                if (|req_valid) begin
                    req_ready = gnt_onehot;
                    gid_d     = gnt_idx;
                    for (int i = 0; i < N; i++) begin
                        if (gnt_onehot[i]) begin
                            op1_d = req_op1[i*FP_W +: FP_W];
                            op2_d = req_op2[i*FP_W +: FP_W];
                        end
                    end
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + 1'b1;
                // A done arriving in the timeout cycle still counts as a real result.
                if (mul_done) begin
                    data_d  = mul_res;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    data_d  = FP_QNAN;
                    err_d   = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    ptr_d   = (gid_q == IDW'(N - 1)) ? '0 : gid_q + 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, operand and response registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            gid_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mul_ready = (state_q == StIssue);
    assign rsp_valid = (state_q == StResp);
    assign busy      = (state_q != StIdle);
    assign mul_op1   = op1_q;
    assign mul_op2   = op2_q;
    assign rsp_id    = gid_q;
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Scoreboard bench for fp_mul_arbiter with a behavioural multiplier and RR order model.
module tb_fp_mul_arbiter;

    localparam int N       = 4;
    localparam int TIMEOUT = 20;
    localparam int IDW     = 2;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*32-1:0]   req_op1, req_op2;
    logic [N-1:0]      req_ready;
    logic              rsp_valid, rsp_ready, rsp_err, mul_ready, mul_done, busy;
    logic [IDW-1:0]    rsp_id;
    logic [31:0]       rsp_data, mul_op1, mul_op2, mul_res;

    fp_mul_arbiter #(
        .N       (N),
        .TIMEOUT (TIMEOUT),
        .IDW     (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op1   (req_op1),
        .req_op2   (req_op2),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .mul_ready (mul_ready),
        .mul_op1   (mul_op1),
        .mul_op2   (mul_op2),
        .mul_res   (mul_res),
        .mul_done  (mul_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IDW-1:0] id;
        logic [31:0]    data;
        logic           err;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          mul_lat = 16;
    int          stall_req = 0;
    int          issue_cyc = 0;
    int          done_cyc = 0;
    int          acc_cyc = 0;
    int          rsp_seen = 0;
    int          mptr = 0;
    logic [31:0] o1[N], o2[N], exp_d[N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference single-precision multiply: RNE, denormals flushed to zero.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [7:0]  ea, eb;
        logic [47:0] p;
        logic [23:0] m;
        logic        g, st;
        int          e;
        s  = a[31] ^ b[31];
        ea = a[30:23];
        eb = b[30:23];
        if ((ea == 8'hFF && a[22:0] != 0) || (eb == 8'hFF && b[22:0] != 0)) return QNAN;
        if (ea == 8'hFF || eb == 8'hFF) begin
            if (ea == 8'h00 || eb == 8'h00) return QNAN;
            return {s, 8'hFF, 23'h0};
        end
        if (ea == 8'h00 || eb == 8'h00) return {s, 31'h0};
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(ea) + int'(eb) - 127;
        if (p[47]) begin
            m = {1'b0, p[46:24]}; g = p[23]; st = |p[22:0]; e++;
        end else begin
            m = {1'b0, p[45:23]}; g = p[22]; st = |p[21:0];
        end
        if (g && (st || m[0])) m = m + 1'b1;
        if (m[23]) begin m = '0; e++; end
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0) return {s, 31'h0};
        return {s, 8'(e), m[22:0]};
    endfunction

    // Behavioural multiplier: done mul_lat cycles after the start pulse; negative = never.
    initial begin
        logic [31:0] a, b;
        mul_done = 1'b0;
        mul_res  = '0;
        forever begin
            @(negedge clk);
            if (mul_ready) begin
                a = mul_op1;
                b = mul_op2;
                issue_cyc = cyc;
                if (mul_lat >= 0) begin
                    repeat (mul_lat) @(posedge clk);
                    #1;
                    mul_res  = fmul(a, b);
                    mul_done = 1'b1;
                    done_cyc = cyc;
                    @(posedge clk);
                    #1 mul_done = 1'b0;
                end
            end
        end
    end

    // Response consumer: holds rsp_ready low for stall_req cycles at the start of each response.
    initial begin
        logic pv;
        int   left;
        pv = 1'b0;
        left = 0;
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rsp_valid && !pv) left = stall_req;
            pv = rsp_valid;
            if (rsp_valid && left > 0) begin
                rsp_ready = 1'b0;
                left--;
            end else begin
                rsp_ready = 1'b1;
            end
        end
    end

    // Monitor: protocol checks and scoreboard pops on every response handshake.
    logic           prev_v = 1'b0, prev_mr = 1'b0;
    logic [IDW-1:0] s_id;
    logic [31:0]    s_data;
    logic           s_err;
    always @(negedge clk) begin
        if (!rst) begin
            prev_v  = 1'b0;
            prev_mr = 1'b0;
        end else begin
            if (req_ready != '0) begin
                check("req_ready_onehot", 128'($onehot(req_ready)), 128'(1));
                check("req_ready_unrequested", 128'(req_ready & ~req_valid), 128'(0));
                acc_cyc = cyc;
            end
            if (mul_ready) begin
                check("mul_ready_single_pulse", 128'(prev_mr), 128'(0));
                check("issue_after_accept", 128'(cyc), 128'(acc_cyc + 1));
            end
            if (rsp_valid) begin
                rsp_seen++;
                check("rsp_blocks_req_ready", 128'(req_ready), 128'(0));
                check("rsp_blocks_mul_ready", 128'(mul_ready), 128'(0));
                if (!prev_v) begin
                    s_id = rsp_id; s_data = rsp_data; s_err = rsp_err;
                    check("rsp_latency", 128'(cyc),
                          128'(rsp_err ? issue_cyc + TIMEOUT + 1 : done_cyc + 1));
                end else begin
                    check("rsp_stable", {rsp_id, rsp_data, rsp_err}, {s_id, s_data, s_err});
                end
                if (rsp_ready) begin
                    check("rsp_expected", 128'(sb.size() != 0), 128'(1));
                    if (sb.size() != 0) begin
                        exp_t e;
                        e = sb.pop_front();
                        check("rsp_id", 128'(rsp_id), 128'(e.id));
                        check("rsp_data", 128'(rsp_data), 128'(e.data));
                        check("rsp_err", 128'(rsp_err), 128'(e.err));
                    end
                end
            end
            prev_v  = rsp_valid;
            prev_mr = mul_ready;
        end
    end

    task automatic check_reset_outputs(input string name);
        check(name, {req_ready, mul_ready, mul_op1, mul_op2, rsp_valid, rsp_id, rsp_data,
                     rsp_err, busy}, 128'(0));
    endtask

    // Present all requesters in mask at once; expected responses follow RR order from mptr.
    task automatic run_batch(input logic [N-1:0] mask);
        logic [N-1:0] pend, acc;
        int           last, bound;
        exp_t         e;
        last = mptr;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (mptr + k) % N;
            if (mask[i]) begin
                e.id   = IDW'(i);
                e.err  = (mul_lat < 0) || (mul_lat > TIMEOUT);
                e.data = e.err ? QNAN : exp_d[i];
                sb.push_back(e);
                last = i;
            end
        end
        mptr = (last + 1) % N;
        for (int i = 0; i < N; i++) begin
            req_op1[i*32 +: 32] = o1[i];
            req_op2[i*32 +: 32] = o2[i];
        end
        req_valid = mask;
        pend = mask;
        bound = 0;
        while (pend != '0 && bound < 2000) begin
            @(negedge clk);
            acc = req_ready & req_valid;
            @(posedge clk);
            #1;
            req_valid = req_valid & ~acc;
            pend = pend & ~acc;
            bound++;
        end
        check("all_accepted", 128'(pend), 128'(0));
        req_valid = '0;
        bound = 0;
        while (sb.size() != 0 && bound < 500) begin
            @(posedge clk);
            bound++;
        end
        check("scoreboard_drained", 128'(sb.size()), 128'(0));
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic [31:0] a, input logic [31:0] b, input logic [31:0] p);
        for (int i = 0; i < N; i++) begin
            o1[i] = a; o2[i] = b; exp_d[i] = p;
        end
    endtask

    initial begin
        int bound, seen0;
        rst = 1'b0;
        req_valid = '0;
        req_op1 = '0;
        req_op2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_outputs");
        @(posedge clk);
        #1 rst = 1'b1;

        // 2.0 x 2.5 on requester 0
        mul_lat = 16;
        set_all(32'h4000_0000, 32'h4020_0000, 32'h40A0_0000);
        run_batch(4'b0001);

        // 100.2 x -0.0 on requester 3 brings ptr back to 0
        set_all(32'h42C8_6666, 32'h8000_0000, 32'h8000_0000);
        run_batch(4'b1000);

        // All four at once: order 0,1,2,3
        mul_lat = 5;
        set_all(32'h3FA0_0000, 32'h3F80_0000, 32'h3FA0_0000);
        run_batch(4'b1111);

        // -inf x 2437.716 on requester 1 moves ptr to 2
        set_all(32'hFF80_0000, 32'h4518_5B75, 32'hFF80_0000);
        run_batch(4'b0010);

        // All four again: order 2,3,0,1
        set_all(32'h3FA0_0000, 32'h3F80_0000, 32'h3FA0_0000);
        run_batch(4'b1111);

        // Consumer stall of 10 cycles while the response is held
        stall_req = 10;
        set_all(32'h4000_0000, 32'h4020_0000, 32'h40A0_0000);
        run_batch(4'b0100);
        stall_req = 0;

        // Watchdog: silent multiplier, done in the timeout cycle, done one cycle late
        mul_lat = -1;
        run_batch(4'b0001);
        mul_lat = TIMEOUT;
        run_batch(4'b0001);
        mul_lat = TIMEOUT + 1;
        run_batch(4'b0001);

        // Reset during WAIT; the stale done lands three cycles after reset takes effect
        mul_lat = 12;
        req_op1[32 +: 32] = 32'h4000_0000;
        req_op2[32 +: 32] = 32'h4000_0000;
        req_valid = 4'b0010;
        bound = 0;
        do begin
            @(negedge clk);
            bound++;
        end while (req_ready == '0 && bound < 100);
        check("reset_test_accept", 128'(req_ready), 128'(4'b0010));
        @(posedge clk);
        #1 req_valid = '0;
        repeat (8) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_op_reset_outputs");
        seen0 = rsp_seen;
        repeat (10) @(posedge clk);
        #1;
        check("stale_done_no_rsp", 128'(rsp_seen - seen0), 128'(0));
        mptr = 0;
        mul_lat = 3;
        set_all(32'h3FA0_0000, 32'h3F80_0000, 32'h3FA0_0000);
        run_batch(4'b1111);

        // Randomized batches against the reference multiply and RR order model
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < N; i++) begin
                o1[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
                o2[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
                exp_d[i] = fmul(o1[i], o2[i]);
            end
            mul_lat = $urandom_range(1, 18);
            stall_req = $urandom_range(0, 3);
            run_batch(4'($urandom_range(1, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_mul_arbiter.md
# fp_mul_arbiter

Round-robin scheduler sharing one IEEE754 single-precision multiplier (ready/done pulse interface, one operation in flight) between N requesters. Accepts operand pairs over per-requester valid/ready handshakes, issues one `ready` pulse to the multiplier, waits for `done`, and returns the product on a shared response bus tagged with the requester index. A watchdog flags a multiplier that never answers.

## Interface
- `N`, 4: number of requesters, 2..8
- `TIMEOUT`, 32: max cycles in WAIT before error; must exceed the multiplier's worst-case latency
- `IDW`, $clog2(N): requester index width
- `clk` in 1: single clock; all logic on the rising edge
- `rst` in 1: one clock; reset is synchronous and active-low (`rst`=0 resets)
- `req_valid` in N: requester i holds an operand pair
- `req_op1`, `req_op2` in N*32: operands; requester i occupies bits [32i+31:32i]
- `req_ready` out N: one-hot accept strobe, at most one bit high
- `rsp_valid` out 1: response available
- `rsp_ready` in 1: consumer accepts the response
- `rsp_id` out IDW: requester index of the response
- `rsp_data` out 32: product
- `rsp_err` out 1: watchdog expired; `rsp_data` = 0x7FC00000
- `mul_ready` out 1: one-cycle start pulse to the multiplier
- `mul_op1`, `mul_op2` out 32: multiplier operands
- `mul_res` in 32: multiplier result
- `mul_done` in 1: multiplier completion pulse
- `busy` out 1: state != IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any `req_valid`, the round-robin pick starting at `ptr` selects index g. `req_ready[g]`=1 in the same cycle (combinational, IDLE only). Latch g and the operands, then go to ISSUE.
- ISSUE: `mul_ready`=1 for exactly one cycle. Clear the watchdog counter, then go to WAIT.
- WAIT: counter increments each cycle.
  - `mul_done`=1: capture `mul_res` into `rsp_data`, `rsp_err`=0, go to RESP.
  - Else if counter == TIMEOUT-1: `rsp_data`=0x7FC00000, `rsp_err`=1, go to RESP.
  - `mul_done` in the same cycle as the timeout: `done` wins.
- RESP: `rsp_valid`=1. `rsp_id`, `rsp_data` and `rsp_err` stay stable until `rsp_valid & rsp_ready`. On that handshake, `ptr` <= (g+1) mod N and go to IDLE.
- `mul_op1`/`mul_op2` hold the latched operands from ISSUE through RESP. They change only on a new accept.
- `mul_done` in IDLE, ISSUE or RESP is ignored.
- Requesters must hold `req_valid` and their operands until accepted. The block never accepts a second request before the response handshake.
- Reset values: state IDLE, `ptr` 0, counter 0. All outputs 0: `req_ready`, `mul_ready`, `mul_op1`, `mul_op2`, `rsp_valid`, `rsp_id`, `rsp_data`, `rsp_err`, `busy`.
- Reset asserted mid-operation: the next cycle is IDLE with all outputs at reset values. The pending request is dropped. A later `mul_done` from the aborted operation is ignored because it arrives outside WAIT.

## Timing
- Accept in cycle t. `mul_ready` high in t+1.
- `mul_done` in cycle d (d >= t+2). `rsp_valid` high from d+1.
- Earliest next accept is the cycle after the response handshake.
- Throughput is one operation per (multiplier latency + 3 + response stall) cycles.
- Fairness: a continuously requesting index is served within N operations.
- All outputs except `req_ready` are registered. `req_ready` is a decode of registered state, `ptr` and `req_valid`.

## Structure
- Package `fp_mul_arb_pkg`:
  - state enum (IDLE/ISSUE/WAIT/RESP)
  - `FP_W`=32
  - `FP_QNAN`=32'h7FC00000
- Sub-module `rr_picker`: combinational, with inputs `req[N]` and `ptr` and outputs `gnt_onehot` and `gnt_idx`. It is reused by other shared-unit schedulers.
- The top holds the FSM, the watchdog counter, and the operand and response registers.

## Test plan
- Single requester 0: op1=0x40000000 (2.0), op2=0x40200000 (2.5), behavioural multiplier with latency 16. Expect one `mul_ready` pulse, then `rsp_data`=0x40A00000, `rsp_id`=0, `rsp_err`=0, `rsp_valid` the cycle after `done`.
- All four requesters valid at once, each pair 0x3FA00000 (1.25) × 0x3F800000 (1.0). Expect grants in order 0,1,2,3 and four responses of 0x3FA00000 with the matching `rsp_id`. Repeat with `ptr`=2 to get the order 2,3,0,1.
- Special values: 0x42C86666 (100.2) × 0x80000000 (-0.0) gives 0x80000000. 0xFF800000 (-inf) × 0x45185B75 (2437.716) gives 0xFF800000.
- `rsp_ready` held low for 10 cycles in RESP. Expect `rsp_*` stable, no new `req_ready`, and `mul_ready` stays low.
- Multiplier never asserts `done`. Expect `rsp_err`=1 and `rsp_data`=0x7FC00000 at TIMEOUT cycles after ISSUE. Also drive `done` in the exact timeout cycle and expect `rsp_err`=0.
- `rst`=0 during WAIT. Expect all outputs 0 next cycle. A stale `mul_done` 3 cycles later produces no response. The next request completes normally with `ptr`=0.
